// File: rtl/hbmc_rst_sequencer.sv
// Reset sequencer for the HyperBus controller clock domain: holds all channel resets for a minimum
// request-free window, then releases them one at a time in index order, gated by a gap and ready_in.
module hbmc_rst_sequencer #(
    parameter int unsigned C_SYNC_STAGES = 3,
    parameter int unsigned C_CHANNELS    = 4,
    parameter int unsigned C_HOLD_CYCLES = 16,
    parameter int unsigned C_GAP_CYCLES  = 8,
    parameter int unsigned C_CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  arst_req,
    input  logic                  soft_req,
    input  logic [C_CHANNELS-1:0] ready_in,
    output logic [C_CHANNELS-1:0] rst_out,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            rst_count
);

    localparam int unsigned IdxW = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1;

    localparam logic [C_CNT_WIDTH-1:0] HoldLast = C_CNT_WIDTH'(C_HOLD_CYCLES - 1);
    localparam logic [C_CNT_WIDTH-1:0] GapLast  = C_CNT_WIDTH'(C_GAP_CYCLES - 1);
    localparam logic [IdxW-1:0]        LastIdx  = IdxW'(C_CHANNELS - 1);

    typedef enum logic [1:0] {
        StHold,
        StGap,
        StWait,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [C_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [C_CHANNELS-1:0]    rst_out_q, rst_out_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [7:0]               rst_count_q, rst_count_d;
    logic [C_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                     req_s;
    logic                     req;

    // Synchroniser resets to all ones so a block reset always implies a full hold window.
    assign sync_d = {sync_q[C_SYNC_STAGES-2:0], arst_req};
    assign req_s  = sync_q[C_SYNC_STAGES-1];
    assign req    = req_s | soft_req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rst_out_d   = rst_out_q;
        busy_d      = busy_q;
        done_d      = done_q;
        rst_count_d = rst_count_q;

        if (req) begin
            // Only a re-entry from a releasing/released state counts; requests in HOLD just restart.
            if (state_q != StHold && rst_count_q != 8'hFF) begin
                rst_count_d = rst_count_q + 8'd1;
            end
            state_d   = StHold;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            busy_d    = 1'b1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                StHold: begin
                    if (cnt_q == HoldLast) begin
                        state_d = StGap;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_CNT_WIDTH'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + C_CNT_WIDTH'(1);
                    end
                end
                StWait: begin
                    if (ready_in[idx_q]) begin
                        rst_out_d[idx_q] = 1'b0;
                        if (idx_q == LastIdx) begin
                            state_d = StDone;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + IdxW'(1);
                            state_d = StGap;
                        end
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StHold;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_out_q   <= '1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            rst_count_q <= 8'd0;
            sync_q      <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_out_q   <= rst_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rst_count_q <= rst_count_d;
            sync_q      <= sync_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rst_count = rst_count_q;

endmodule

// File: tb/tb_hbmc_rst_sequencer.sv
// Directed bench for hbmc_rst_sequencer: every edge is checked against hand-derived release edges.
module tb_hbmc_rst_sequencer;

    logic       clk;
    logic       rstn;
    logic       arst_req;
    logic       soft_req;
    logic [3:0] ready_in;
    logic [3:0] rst_out;
    logic       busy;
    logic       done;
    logic [7:0] rst_count;

    int n_checks;
    int n_errors;
    int edge_n;
    int rel_edge [4];
    int exp_cnt;

    localparam int Never = 99999;

    hbmc_rst_sequencer dut (
        .clk       (clk),
        .rstn      (rstn),
        .arst_req  (arst_req),
        .soft_req  (soft_req),
        .ready_in  (ready_in),
        .rst_out   (rst_out),
        .busy      (busy),
        .done      (done),
        .rst_count (rst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic set_rel(input int r0, input int r1, input int r2, input int r3);
        rel_edge[0] = r0;
        rel_edge[1] = r1;
        rel_edge[2] = r2;
        rel_edge[3] = r3;
    endtask

    // Advance one edge, then compare all outputs against the release schedule in rel_edge.
    task automatic step_check();
        logic [3:0] exp_rst;
        @(posedge clk);
        #1;
        edge_n++;
        for (int i = 0; i < 4; i++) exp_rst[i] = (edge_n >= rel_edge[i]) ? 1'b0 : 1'b1;
        check_eq("rst_out", 32'(rst_out), 32'(exp_rst));
        check_eq("busy", 32'(busy), 32'(exp_rst != 4'b0));
        check_eq("done", 32'(done), 32'(exp_rst == 4'b0));
        check_eq("rst_count", 32'(rst_count), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        exp_cnt = 0;
        set_rel(Never, Never, Never, Never);
        step_check();
        step_check();
        rstn   = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        edge_n   = 0;
        rstn     = 1'b0;
        arst_req = 1'b0;
        soft_req = 1'b0;
        ready_in = 4'hF;

        // Default timing with all channels ready.
        do_reset();
        set_rel(28, 37, 46, 55);
        while (edge_n < 60) step_check();

        // Channel 1 stalls in WAIT until ready_in[1] is sampled high at edge 61.
        do_reset();
        ready_in = 4'b0001;
        set_rel(28, 61, 70, 79);
        while (edge_n < 85) begin
            step_check();
            if (edge_n == 60) ready_in = 4'hF;
        end

        // One-cycle soft request in DONE restarts without sync delay.
        soft_req = 1'b1;
        edge_n   = -1;
        exp_cnt  = 1;
        set_rel(25, 34, 43, 52);
        step_check();
        soft_req = 1'b0;
        while (edge_n < 56) step_check();

        // Re-entry from DONE, then pulses every 10 edges in HOLD keep restarting the hold window.
        soft_req = 1'b1;
        edge_n   = -1;
        exp_cnt  = 2;
        set_rel(85, 94, 103, 112);
        step_check();
        soft_req = 1'b0;
        while (edge_n < 96) begin
            step_check();
            soft_req = (edge_n % 10 == 9) && (edge_n < 60);
        end

        // Asynchronous request mid-GAP after channel 1 release; seen at edges 100..102.
        #2 arst_req = 1'b1;
        step_check();
        step_check();
        step_check();
        arst_req = 1'b0;
        exp_cnt  = 3;
        set_rel(127, 136, 145, 154);
        while (edge_n < 136) step_check();

        // Two more GAP re-entries bring rst_count to 5; then stall channel 1 in WAIT.
        soft_req = 1'b1;
        exp_cnt  = 4;
        set_rel(162, 171, 180, 189);
        step_check();
        soft_req = 1'b0;
        while (edge_n < 154) step_check();
        soft_req = 1'b1;
        exp_cnt  = 5;
        set_rel(180, Never, Never, Never);
        step_check();
        soft_req = 1'b0;
        ready_in = 4'b0001;
        while (edge_n < 191) step_check();

        // Block reset in WAIT clears everything; afterwards timing matches the first run.
        rstn    = 1'b0;
        exp_cnt = 0;
        set_rel(Never, Never, Never, Never);
        step_check();
        step_check();
        rstn     = 1'b1;
        ready_in = 4'hF;
        edge_n   = 0;
        set_rel(28, 37, 46, 55);
        while (edge_n < 60) step_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
